// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack-style ALU with valid/ready flow control.
// Stage 1 conditions the operands (zx/nx/zy/ny), stage 2 computes and registers result and flags.
module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);

    function automatic logic [WIDTH-1:0] condition(
        input logic [WIDTH-1:0] v,
        input logic             z,
        input logic             n
    );
        logic [WIDTH-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_xf;
    logic [WIDTH-1:0] s1_yf;
    logic             s1_f;
    logic             s1_no;

    logic             s2_valid;

    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;
    logic             co_next;
    logic             ov_next;

    // Ready ripples back combinationally so a full pipe still streams one beat per cycle.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = rst_n && s1_adv;
    end

    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_xf    <= '0;
            s1_yf    <= '0;
            s1_f     <= 1'b0;
            s1_no    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_xf <= condition(x, zx, nx);
                s1_yf <= condition(y, zy, ny);
                s1_f  <= f;
                s1_no <= no;
            end
        end
    end

    // Carry and overflow describe the add itself, before the optional output inversion.
    always_comb begin
        sum     = {1'b0, s1_xf} + {1'b0, s1_yf};
        r       = s1_f ? sum[WIDTH-1:0] : (s1_xf & s1_yf);
        res     = s1_no ? ~r : r;
        co_next = s1_f & sum[WIDTH];
        ov_next = s1_f & (s1_xf[WIDTH-1] == s1_yf[WIDTH-1])
                       & (sum[WIDTH-1] != s1_xf[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            zr       <= 1'b0;
            ng       <= 1'b0;
            co       <= 1'b0;
            ov       <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            // An empty stage 1 leaves the last result on the outputs.
            if (s1_valid) begin
                out <= res;
                zr  <= (res == '0);
                ng  <= res[WIDTH-1];
                co  <= co_next;
                ov  <= ov_next;
            end
        end
    end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Scoreboard bench for hack_alu_pipe (WIDTH=16): directed vectors with hand-computed results.
module tb_hack_alu_pipe;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx, nx, zy, ny, f, no;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr, ng, co, ov;

    hack_alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng), .co(co), .ov(ov)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o;
        logic [3:0]  fl;   // {zr, ng, co, ov}
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares the head of the queue whenever a result is presented,
    // popping only when it actually transfers; a stalled result is re-checked each cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'h0);
            end else begin
                check("out", 32'(out), 32'(q[0].o));
                check("flags", 32'({zr, ng, co, ov}), 32'(q[0].fl));
                if (out_ready === 1'b1) begin
                    if (chk_lat) check("latency", 32'(cyc - q[0].acc), 32'd2);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] ctl,
                        input logic [15:0] eo, input logic [3:0] efl);
        exp_t e;
        int   n;
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = ctl;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(in_ready), 32'h1);
        end else begin
            e.o   = eo;
            e.fl  = efl;
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(q.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; {zx, nx, zy, ny, f, no} = 6'b0;
        @(negedge clk);
        check("in_ready_in_reset", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out", 32'(out), 32'h0);
        check("reset_flags", 32'({zr, ng, co, ov}), 32'h0);
        check("ready_after_reset", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // Single beats with latency checking; control order {zx,nx,zy,ny,f,no}.
        chk_lat = 1'b1;
        send(16'h0005, 16'h0003, 6'b000010, 16'h0008, 4'b0000);
        drain();
        send(16'h0003, 16'h0005, 6'b010011, 16'hFFFE, 4'b0110);
        drain();
        send(16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 4'b0101);
        send(16'h1234, 16'h5678, 6'b101010, 16'h0000, 4'b1000);
        send(16'hF0F0, 16'hFF00, 6'b000000, 16'hF000, 4'b0100);
        drain();

        // Back-to-back stream of 8 with out_ready high.
        send(16'h0001, 16'h0001, 6'b000010, 16'h0002, 4'b0000);
        send(16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 4'b1010);
        send(16'h8000, 16'h8000, 6'b000010, 16'h0000, 4'b1011);
        send(16'h1234, 16'h00FF, 6'b110000, 16'h00FF, 4'b0000);
        send(16'h00AA, 16'h0055, 6'b000001, 16'hFFFF, 4'b0100);
        send(16'h0000, 16'h0000, 6'b010110, 16'hFFFE, 4'b0110);
        send(16'h0010, 16'h9999, 6'b011111, 16'h0011, 4'b0010);
        send(16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 4'b0100);
        drain();

        // Backpressure: two beats fill the pipe, in_ready must drop, results held.
        chk_lat = 1'b0;
        out_ready = 1'b0;
        send(16'h0002, 16'h0003, 6'b000010, 16'h0005, 4'b0000);
        @(negedge clk);
        check("ready_one_queued", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        send(16'h0010, 16'h0020, 6'b000010, 16'h0030, 4'b0000);
        @(negedge clk);
        check("ready_two_queued", 32'(in_ready), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0004, 16'h0004, 6'b000010, 16'h0008, 4'b0000);
        send(16'h000F, 16'h00F0, 6'b000000, 16'h0000, 4'b1000);
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 6'b000010, 16'h0003, 4'b0000);
        send(16'h0003, 16'h0004, 6'b000010, 16'h0007, 4'b0000);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        check("in_ready_in_mid_reset", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 32'(out_valid), 32'h0);
        check("post_reset_out", 32'(out), 32'h0);
        check("post_reset_flags", 32'({zr, ng, co, ov}), 32'h0);
        check("post_reset_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        chk_lat = 1'b1;
        send(16'h0100, 16'h0001, 6'b000010, 16'h0101, 4'b0000);
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
